// File: rtl/if_stage_if.sv
// Fetch-stage bus: ROM port, decode-side control inputs and IF/ID register outputs.
interface if_stage_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        flush;
    logic [2:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        ifid_misalign;

    modport master (
        output rom_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, ifid_misalign,
        input  rom_data, stall, flush, pc_src, branch_target, jump_target, jr_target
    );

    modport slave (
        input  rom_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, ifid_misalign,
        output rom_data, stall, flush, pc_src, branch_target, jump_target, jr_target
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select with irq/exception vectors, IF/ID register.
// Optional IF_MISALIGN_DETECT_EN: word-aligned ROM address and misaligned-fetch tagging.
module if_stage (
    input  logic      clk,
    input  logic      reset,
    if_stage_if.master bus
);
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_PC   = 32'h8000_0004;
    localparam logic [31:0] EXC_PC   = 32'h8000_0008;

    logic [31:0] pc_q, pc_plus4, pc_next, fetch_addr;
    logic [31:0] instr_q, pp4_q;
    logic        valid_q, mis_q, trap, misaligned;

    // Kernel bit survives the increment so user code never wraps into kernel space.
    assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};

    always_comb begin
        pc_next = bus.stall ? pc_q : pc_plus4;
        trap    = 1'b0;
        case (bus.pc_src)
            3'd1: pc_next = bus.branch_target;
            3'd2: pc_next = bus.jump_target;
            3'd3: pc_next = bus.jr_target;
            3'd4: if (!pc_q[31]) begin
                pc_next = IRQ_PC;
                trap    = 1'b1;
            end
            3'd5: begin
                pc_next = EXC_PC;
                trap    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef IF_MISALIGN_DETECT_EN
    assign fetch_addr = {pc_q[31:2], 2'b00};
    assign misaligned = |pc_q[1:0];
`else
    assign fetch_addr = pc_q;
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pp4_q   <= 32'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (trap || bus.flush) begin
                instr_q <= 32'h0;
                pp4_q   <= pc_plus4;
                valid_q <= 1'b0;
                mis_q   <= 1'b0;
            end else if (!bus.stall) begin
                // A misaligned fetch still occupies a slot so decode can raise the fault.
                instr_q <= misaligned ? 32'h0 : bus.rom_data;
                pp4_q   <= pc_plus4;
                valid_q <= 1'b1;
                mis_q   <= misaligned;
            end
        end
    end

    assign bus.rom_addr      = fetch_addr;
    assign bus.pc            = pc_q;
    assign bus.ifid_instr    = instr_q;
    assign bus.ifid_pc_plus4 = pp4_q;
    assign bus.ifid_valid    = valid_q;
    assign bus.ifid_misalign = mis_q;
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver pushes expected IF/ID+PC state, monitor compares after each edge.
module tb_if_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    if_stage_if bus();
    if_stage dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Model state, updated only by spec rules
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_mis;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a - 32'h8000_0000) >> 2;
    endfunction

    assign bus.rom_data = rom_word(bus.rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_instr = 0; m_pp4 = 0; m_valid = 0; m_mis = 0;
    endtask

    // Drive one cycle of inputs now, advance the model, queue the post-edge expectation.
    task automatic drive_and_push(input logic st, input logic fl, input logic [2:0] src,
                                  input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
        logic [31:0] seq_pc, npc, faddr;
        logic        take_trap, odd;
        exp_t e;
        bus.stall = st; bus.flush = fl; bus.pc_src = src;
        bus.branch_target = bt; bus.jump_target = jt; bus.jr_target = jrt;
        seq_pc = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
`ifdef IF_MISALIGN_DETECT_EN
        faddr = m_pc & 32'hFFFF_FFFC;
        odd   = (m_pc % 4) != 0;
`else
        faddr = m_pc;
        odd   = 1'b0;
`endif
        chk("rom_addr", bus.rom_addr, faddr);
        take_trap = 1'b0;
        if (src == 3'd5) begin npc = 32'h8000_0008; take_trap = 1'b1; end
        else if (src == 3'd4 && m_pc < 32'h8000_0000) begin npc = 32'h8000_0004; take_trap = 1'b1; end
        else if (src == 3'd3) npc = jrt;
        else if (src == 3'd2) npc = jt;
        else if (src == 3'd1) npc = bt;
        else if (st) npc = m_pc;
        else npc = seq_pc;
        if (take_trap || fl) begin
            m_instr = 0; m_pp4 = seq_pc; m_valid = 0; m_mis = 0;
        end else if (!st) begin
            m_instr = odd ? 32'h0 : rom_word(faddr);
            m_pp4 = seq_pc; m_valid = 1; m_mis = odd;
        end
        m_pc = npc;
        e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid; e.mis = m_mis;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic st, input logic fl, input logic [2:0] src,
                        input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
        @(negedge clk);
        drive_and_push(st, fl, src, bt, jt, jrt);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pc"}, bus.pc, 32'h8000_0000);
        chk({tag, "_instr"}, bus.ifid_instr, 32'h0);
        chk({tag, "_pp4"}, bus.ifid_pc_plus4, 32'h0);
        chk({tag, "_valid"}, {31'b0, bus.ifid_valid}, 32'h0);
        chk({tag, "_mis"}, {31'b0, bus.ifid_misalign}, 32'h0);
    endtask

    // Monitor: every edge with an outstanding expectation gets compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", bus.pc, e.pc);
                chk("ifid_instr", bus.ifid_instr, e.instr);
                chk("ifid_pc_plus4", bus.ifid_pc_plus4, e.pp4);
                chk("ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, e.valid});
                chk("ifid_misalign", {31'b0, bus.ifid_misalign}, {31'b0, e.mis});
            end
        end
    end

    initial begin
        bus.stall = 0; bus.flush = 0; bus.pc_src = 0;
        bus.branch_target = 0; bus.jump_target = 0; bus.jr_target = 0;
        #1 reset = 1'b0;
        #1 chk_reset_outs("rst_async");
        @(posedge clk); #1 chk_reset_outs("rst_held");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive_and_push(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        // stall hold, then redirect under stall
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 3'd1, 32'h8000_0020, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // irq in user mode vs kernel mode
        step(0, 0, 3'd3, 0, 0, 32'h0000_0010);
        step(0, 0, 3'd4, 0, 0, 0);
        step(0, 0, 3'd3, 0, 0, 32'h8000_0010);
        step(0, 0, 3'd4, 0, 0, 0);
        // exception under stall, pc_plus4 wrap boundaries
        step(1, 0, 3'd5, 0, 0, 0);
        step(0, 0, 3'd3, 0, 0, 32'h7FFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 3'd3, 0, 0, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        // misaligned fetch, flush, pc_src 6/7
        step(0, 0, 3'd3, 0, 0, 32'h0000_0102);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 3'd6, 32'h1234_0000, 0, 0);
        step(1, 0, 3'd7, 0, 32'h5555_0000, 0);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) == 0) t[31] = ~t[31];
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, 3'($urandom_range(0, 7)),
                 $urandom, t, {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'($urandom)});
        end
        // Reset mid stall+jump: pending jump must be discarded
        @(posedge clk); #2;
        bus.stall = 1; bus.pc_src = 3'd2; bus.jump_target = 32'h0000_4000;
        #1 reset = 1'b0;
        #1 chk_reset_outs("rst_mid");
        @(posedge clk); #1 chk_reset_outs("rst_mid_held");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive_and_push(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2 chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
